// File: rtl/reg_apb_bridge.sv
// reg_apb_bridge: APB3 slave front end for the VT100 register block.
// Ports: APB slave (psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr),
// register bus (reg_sel one-hot, reg_wr_rd, reg_wr_data, reg_rd_bus in).
module reg_apb_bridge #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int REG_NUM    = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [REG_WIDTH-1:0]         pwdata,
    output logic [REG_WIDTH-1:0]         prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [REG_NUM-1:0]           reg_sel,
    output logic                         reg_wr_rd,
    output logic [REG_WIDTH-1:0]         reg_wr_data,
    input  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_bus
);

    localparam int IW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int AW = ADDR_WIDTH - 2;
    localparam logic [1:0] LAT = 2'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [REG_WIDTH-1:0]   prdata_d;
    logic                   pready_d;
    logic                   pslverr_d;
    logic [REG_NUM-1:0]     sel_d;
    logic                   wr_rd_d;
    logic [REG_WIDTH-1:0]   wr_data_d;

    logic [AW-1:0]          word;
    logic                   hit;
    logic                   setup;
    logic [REG_WIDTH-1:0]   rd_arr [REG_NUM];

    for (genvar i = 0; i < REG_NUM; i++) begin : g_rd
        assign rd_arr[i] = reg_rd_bus[i*REG_WIDTH +: REG_WIDTH];
    end

    assign word  = paddr[ADDR_WIDTH-1:2];
    // Extra MSB lets REG_NUM equal the full word-address space.
    assign hit   = (paddr[1:0] == 2'b00) &&
                   ({1'b0, word} < (AW+1)'(REG_NUM));
    assign setup = psel && !penable;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        prdata_d  = prdata;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        sel_d     = '0;
        wr_rd_d   = reg_wr_rd;
        wr_data_d = reg_wr_data;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    if (hit) begin
                        // Select is registered, so it is high in the
                        // first access cycle.
                        idx_d     = paddr[IW+1:2];
                        sel_d     = REG_NUM'(1) << paddr[IW+1:2];
                        wr_rd_d   = pwrite;
                        wr_data_d = pwdata;
                        state_d   = ISSUE;
                    end else begin
                        prdata_d  = '0;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = ERR;
                    end
                end
            end
            ISSUE: begin
                if (reg_wr_rd) begin
                    pready_d = 1'b1;
                    state_d  = RESP;
                end else if (RD_LAT == 0) begin
                    prdata_d = rd_arr[idx_q];
                    pready_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d   = 2'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    prdata_d = rd_arr[idx_q];
                    pready_d = 1'b1;
                    cnt_d    = 2'd0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            prdata      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            reg_sel     <= '0;
            reg_wr_rd   <= 1'b0;
            reg_wr_data <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            prdata      <= prdata_d;
            pready      <= pready_d;
            pslverr     <= pslverr_d;
            reg_sel     <= sel_d;
            reg_wr_rd   <= wr_rd_d;
            reg_wr_data <= wr_data_d;
        end
    end

endmodule
